// File: rtl/writeback_stage_pkg.sv
// Shared RV32I core types: datapath widths, writeback source and load size encodings.
// No logic of its own; pure declarations plus one lane-extension helper.
// Used by the writeback stage and the store-path checker.
package writeback_stage_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int INSTRET_W  = 64;

    // Writeback source select; codes 5..7 are undefined and never write.
    typedef enum logic [2:0] {
        WB_ALU  = 3'd0,
        WB_LOAD = 3'd1,
        WB_PC4  = 3'd2,
        WB_IMM  = 3'd3,
        WB_CSR  = 3'd4
    } wb_sel_t;

    // Load access size; the unused code 3 behaves as a word access.
    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } load_size_t;

    // Widen an extracted byte or halfword lane to 32 bits, sign- or zero-filled.
    function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                                input logic        is_half,
                                                input logic        zero_ext);
        logic fill;
        fill = is_half ? lane[15] : lane[7];
        if (zero_ext) begin
            fill = 1'b0;
        end
        if (is_half) begin
            extend_lane = {{16{fill}}, lane};
        end else begin
            extend_lane = {{24{fill}}, lane[7:0]};
        end
    endfunction

endpackage

// File: rtl/writeback_stage_load_align_ext.sv
// Load lane extraction with sign/zero extension and alignment check for RV32I loads.
// Purely combinational, zero latency.
// No flow control; caller qualifies the misaligned flag with its own load indication.
module load_align_ext
    import writeback_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  addr_lsb,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and halfword lanes out of the aligned word.
    always_comb begin
        byte_lane = word[7:0];
        case (addr_lsb)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lsb[1] ? word[31:16] : word[15:0];
    end

    // Size-dependent result and alignment; the reserved size code acts as a word.
    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (size)
            LS_BYTE: begin
                data       = extend_lane({8'h00, byte_lane}, 1'b0, zero_ext);
                misaligned = 1'b0;
            end
            LS_HALF: begin
                data       = extend_lane(half_lane, 1'b1, zero_ext);
                misaligned = addr_lsb[0];
            end
            default: begin
                data       = word;
                misaligned = (addr_lsb != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final RV32I stage: selects/extends the result and drives the register file write port.
// One cycle from input edge to write-port drive; instret counts on the following edge.
// stall_in holds the entry (write fires once only); flush_in captures a bubble.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN       = writeback_stage_pkg::XLEN,
    parameter int REG_ADDR_W = writeback_stage_pkg::REG_ADDR_W,
    parameter int INSTRET_W  = writeback_stage_pkg::INSTRET_W
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  valid_in,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  rf_wr_req_in,
    input  logic [2:0]            wb_sel_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       load_word_in,
    input  logic [1:0]            load_size_in,
    input  logic                  load_unsigned_in,
    input  logic [1:0]            addr_lsb_in,
    input  logic [XLEN-1:0]       pc_plus_4_in,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [XLEN-1:0]       csr_data_in,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic                  wr_en_out,
    output logic [XLEN-1:0]       rd_out,
    output logic                  misaligned_load_out,
    output logic [INSTRET_W-1:0]  instret_out
);

    logic [XLEN-1:0] load_data;
    logic            load_misaligned_raw;
    logic [XLEN-1:0] sel_data;
    logic            sel_legal;
    logic            next_misaligned;
    logic            next_wr_ok;

    // Entry state: valid/fresh qualify the registered write and exception pulses.
    logic                  valid_q;
    logic                  fresh_q;
    logic                  entry_mis_q;
    logic                  wr_en_q;
    logic                  mis_pulse_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [XLEN-1:0]       rd_q;
    logic [INSTRET_W-1:0]  instret_q;

    load_align_ext u_load_align_ext (
        .word       (load_word_in),
        .size       (load_size_in),
        .zero_ext   (load_unsigned_in),
        .addr_lsb   (addr_lsb_in),
        .data       (load_data),
        .misaligned (load_misaligned_raw)
    );

    // Writeback source mux; undefined select codes yield zero data and no write.
    always_comb begin
        sel_data  = '0;
        sel_legal = 1'b1;
        case (wb_sel_in)
            WB_ALU:  sel_data = alu_result_in;
            WB_LOAD: sel_data = load_data;
            WB_PC4:  sel_data = pc_plus_4_in;
            WB_IMM:  sel_data = imm_in;
            WB_CSR:  sel_data = csr_data_in;
            default: begin
                sel_data  = '0;
                sel_legal = 1'b0;
            end
        endcase
    end

    // Alignment only matters for actual loads; x0 and illegal selects never write.
    always_comb begin
        next_misaligned = valid_in && (wb_sel_in == WB_LOAD) && load_misaligned_raw;
        next_wr_ok      = valid_in && rf_wr_req_in && (rd_addr_in != '0)
                          && sel_legal && !load_misaligned_raw_gate();
    end

    function automatic logic load_misaligned_raw_gate();
        return (wb_sel_in == WB_LOAD) && load_misaligned_raw;
    endfunction

    // Stage register: capture, bubble on flush, hold on stall with fresh cleared.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            valid_q     <= 1'b0;
            fresh_q     <= 1'b0;
            entry_mis_q <= 1'b0;
            wr_en_q     <= 1'b0;
            mis_pulse_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_q        <= '0;
        end else if (flush_in) begin
            valid_q     <= 1'b0;
            fresh_q     <= 1'b0;
            entry_mis_q <= 1'b0;
            wr_en_q     <= 1'b0;
            mis_pulse_q <= 1'b0;
        end else if (!stall_in) begin
            valid_q     <= valid_in;
            fresh_q     <= 1'b1;
            entry_mis_q <= next_misaligned;
            wr_en_q     <= next_wr_ok;
            mis_pulse_q <= next_misaligned;
            rd_addr_q   <= rd_addr_in;
            rd_q        <= sel_data;
        end else begin
            fresh_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            mis_pulse_q <= 1'b0;
        end
    end

    // Retire on the edge that ends an entry's fresh cycle; wraps naturally.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            instret_q <= '0;
        end else if (valid_q && fresh_q && !entry_mis_q) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign rd_addr_out         = rd_addr_q;
    assign rd_out              = rd_q;
    assign wr_en_out           = wr_en_q;
    assign misaligned_load_out = mis_pulse_q;
    assign instret_out         = instret_q;

endmodule
